ft60x_axi_buffer: RTL and testbench
===================================

FT60X_AXI_BUFFER -- requirements
Module: ft60x_axi_buffer

Interface
REQ-001 Parameter ADDR_W, default 32: AW/AR address width.
REQ-002 Parameter DATA_W, default 32: W/R data width; multiple of 8; WSTRB width is DATA_W/8.
REQ-003 Parameter ID_W, default 4: AXI ID width on AW, AR, B and R.
REQ-004 Parameter DEPTH, default 2: entries per channel buffer; power of two, at least 2.
REQ-005 Parameter BYPASS, default 5'b00000: per-channel pass-through mask; bit 0 AW, 1 W, 2 B, 3 AR, 4 R; 1 means combinational pass-through.
REQ-006 Parameter MAX_OUT, default 0: outstanding-burst limit per direction; 0 means unlimited.
REQ-007 Port clk_i, input, 1: sole clock; all logic is on its rising edge.
REQ-008 Port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-009 Port group inport_aw*, AW slave: awvalid_i 1, awaddr_i ADDR_W, awid_i ID_W, awlen_i 8, awburst_i 2, awready_o 1.
REQ-010 Port group inport_w*, W slave: wvalid_i 1, wdata_i DATA_W, wstrb_i DATA_W/8, wlast_i 1, wready_o 1.
REQ-011 Port group inport_b*, B slave: bvalid_o 1, bresp_o 2, bid_o ID_W, bready_i 1.
REQ-012 Port group inport_ar*, AR slave: same fields and widths as AW, ar prefix.
REQ-013 Port group inport_r*, R slave: rvalid_o 1, rdata_o DATA_W, rresp_o 2, rid_o ID_W, rlast_o 1, rready_i 1.
REQ-014 Port group outport_*, master: mirror of REQ-009 to REQ-013 with directions reversed.
REQ-015 Port wr_outstanding_o, output, clog2(MAX_OUT+1) (1 if MAX_OUT=0): write bursts issued and not yet responded.
REQ-016 Port rd_outstanding_o, output, same width as wr_outstanding_o: read bursts issued and not yet completed.

Function
REQ-017 Each channel with its BYPASS bit at 0 SHALL be a DEPTH-entry FIFO: push = source valid AND accept; pop = valid_o AND sink ready.
REQ-018 FIFO valid_o SHALL equal (count != 0), and accept SHALL equal (count != DEPTH), both from registered count only.
REQ-019 Data SHALL appear at the FIFO output one cycle after the push edge; valid cannot go high in the push cycle.
REQ-020 Output data SHALL be ram[rd_ptr]; pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; push when full is refused; pop when empty is ignored.
REQ-022 Each channel with its BYPASS bit at 1 SHALL connect valid, ready and payload combinationally, with no storage and zero latency.
REQ-023 Write counter SHALL increment on an outport AW handshake, decrement on an inport B handshake, and hold when both occur in the same cycle.
REQ-024 Read counter SHALL increment on an outport AR handshake, decrement on an inport R handshake with rlast=1, and hold when both occur in the same cycle.
REQ-025 When MAX_OUT>0 and the write counter equals MAX_OUT, outport_awvalid_o SHALL be 0 and the AW buffer SHALL not pop.
REQ-026 When MAX_OUT>0 and the read counter equals MAX_OUT, outport_arvalid_o SHALL be 0 and the AR buffer SHALL not pop.
REQ-027 Counters SHALL never wrap; a decrement at 0 is ignored.
REQ-028 When MAX_OUT=0 the counters SHALL saturate at their maximum and never gate AW or AR.
REQ-029 Payload packing order per channel is fixed in the package and SHALL be identical for push and pop.
REQ-030 W, B and R beats SHALL pass in order, unmodified, and SHALL NOT be gated by the counters.

Reset
REQ-031 While rst_ni=0, all counts, pointers and counters SHALL be 0, all valid outputs 0, and all ready outputs of buffered channels 1 from the first cycle after release; RAM contents are not reset.
REQ-032 Reset asserted mid-burst SHALL discard all buffered entries immediately; no partial beat is emitted after release.

Structure
REQ-033 Shared package ft60x_axi_pkg SHALL hold AXI response encodings, channel bit indices for BYPASS, and per-channel payload width functions of ADDR_W, DATA_W and ID_W.
REQ-034 One sub-module, ft60x_axi_fifo (parameters WIDTH, DEPTH), SHALL be instantiated per non-bypassed channel via generate.

Verification
REQ-035 DEPTH=4, AW sink ready held 0, push 5 AWs -> awready_o falls after the 4th; the 5th stalls; after release, addresses emerge in order.
REQ-036 DEPTH=2, full FIFO with push and pop every cycle for 8 cycles -> count stays 2, no beat lost or duplicated, pointers wrap 4 times.
REQ-037 MAX_OUT=2, issue 3 ARs, hold rready_i=0 -> 2 ARs leave, outport_arvalid_o=0, rd_outstanding_o=2; one R beat with rlast=1 -> the 3rd AR issues next cycle.
REQ-038 BYPASS=5'b11111 -> every output equals its input in the same cycle; wvalid_i=1 with wdata_i=0xDEADBEEF gives outport_wdata_o=0xDEADBEEF at zero latency.
REQ-039 Same-cycle B handshake and new AW handshake at wr_outstanding_o=1 -> counter stays 1.
REQ-040 rst_ni pulled low with 2 entries in every FIFO -> all valids 0 immediately; after release, readies are 1 and counters are 0.

Source files
------------

// File: rtl/ft60x_axi_pkg.sv
// Shared definitions for the FT60x AXI channel buffer.
// Response codes, BYPASS bit indices and payload widths.
package ft60x_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  // Packing: {addr, id, len, burst}
  function automatic int ax_width(int addr_w, int id_w);
    return addr_w + id_w + 8 + 2;
  endfunction

  // Packing: {data, strb, last}
  function automatic int w_width(int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  // Packing: {resp, id}
  function automatic int b_width(int id_w);
    return 2 + id_w;
  endfunction

  // Packing: {data, resp, id, last}
  function automatic int r_width(int data_w, int id_w);
    return data_w + 2 + id_w + 1;
  endfunction

endpackage

// File: rtl/ft60x_axi_fifo.sv
// Single-channel valid/ready FIFO for the AXI buffer.
// Flags come from the registered count only.
module ft60x_axi_fifo
  import ft60x_axi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             accept_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             push;
  logic             pop;

  assign valid_o  = (count != '0);
  assign accept_o = (count != FULL);
  assign push     = valid_i & accept_o;
  assign pop      = valid_o & ready_i;
  assign data_o   = ram[rd_ptr];

  // Storage is left unreset; count alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (push) ram[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ft60x_axi_buffer.sv
// Five-channel AXI buffer with per-channel bypass and an
// optional cap on outstanding write and read bursts.
module ft60x_axi_buffer
  import ft60x_axi_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter int         ID_W    = 4,
  parameter int         DEPTH   = 2,
  parameter logic [4:0] BYPASS  = 5'b00000,
  parameter int         MAX_OUT = 0,
  localparam int CW = (MAX_OUT == 0) ? 1 : $clog2(MAX_OUT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inport_awvalid_i,
  input  logic [ADDR_W-1:0]   inport_awaddr_i,
  input  logic [ID_W-1:0]     inport_awid_i,
  input  logic [7:0]          inport_awlen_i,
  input  logic [1:0]          inport_awburst_i,
  output logic                inport_awready_o,
  input  logic                inport_wvalid_i,
  input  logic [DATA_W-1:0]   inport_wdata_i,
  input  logic [DATA_W/8-1:0] inport_wstrb_i,
  input  logic                inport_wlast_i,
  output logic                inport_wready_o,
  output logic                inport_bvalid_o,
  output logic [1:0]          inport_bresp_o,
  output logic [ID_W-1:0]     inport_bid_o,
  input  logic                inport_bready_i,
  input  logic                inport_arvalid_i,
  input  logic [ADDR_W-1:0]   inport_araddr_i,
  input  logic [ID_W-1:0]     inport_arid_i,
  input  logic [7:0]          inport_arlen_i,
  input  logic [1:0]          inport_arburst_i,
  output logic                inport_arready_o,
  output logic                inport_rvalid_o,
  output logic [DATA_W-1:0]   inport_rdata_o,
  output logic [1:0]          inport_rresp_o,
  output logic [ID_W-1:0]     inport_rid_o,
  output logic                inport_rlast_o,
  input  logic                inport_rready_i,
  output logic                outport_awvalid_o,
  output logic [ADDR_W-1:0]   outport_awaddr_o,
  output logic [ID_W-1:0]     outport_awid_o,
  output logic [7:0]          outport_awlen_o,
  output logic [1:0]          outport_awburst_o,
  input  logic                outport_awready_i,
  output logic                outport_wvalid_o,
  output logic [DATA_W-1:0]   outport_wdata_o,
  output logic [DATA_W/8-1:0] outport_wstrb_o,
  output logic                outport_wlast_o,
  input  logic                outport_wready_i,
  input  logic                outport_bvalid_i,
  input  logic [1:0]          outport_bresp_i,
  input  logic [ID_W-1:0]     outport_bid_i,
  output logic                outport_bready_o,
  output logic                outport_arvalid_o,
  output logic [ADDR_W-1:0]   outport_araddr_o,
  output logic [ID_W-1:0]     outport_arid_o,
  output logic [7:0]          outport_arlen_o,
  output logic [1:0]          outport_arburst_o,
  input  logic                outport_arready_i,
  input  logic                outport_rvalid_i,
  input  logic [DATA_W-1:0]   outport_rdata_i,
  input  logic [1:0]          outport_rresp_i,
  input  logic [ID_W-1:0]     outport_rid_i,
  input  logic                outport_rlast_i,
  output logic                outport_rready_o,
  output logic [CW-1:0]       wr_outstanding_o,
  output logic [CW-1:0]       rd_outstanding_o
);

  localparam int AXW = ax_width(ADDR_W, ID_W);
  localparam int WW  = w_width(DATA_W);
  localparam int BW  = b_width(ID_W);
  localparam int RW  = r_width(DATA_W, ID_W);
  localparam logic [CW-1:0] CMAX =
    (MAX_OUT == 0) ? {CW{1'b1}} : CW'(MAX_OUT);

  logic [AXW-1:0] aw_s_data, aw_m_data;
  logic [AXW-1:0] ar_s_data, ar_m_data;
  logic [WW-1:0]  w_s_data,  w_m_data;
  logic [BW-1:0]  b_s_data,  b_m_data;
  logic [RW-1:0]  r_s_data,  r_m_data;
  logic           aw_m_valid, aw_m_ready;
  logic           ar_m_valid, ar_m_ready;
  logic [CW-1:0]  wr_cnt, rd_cnt;
  logic           wr_full, rd_full;
  logic           aw_hs, b_hs, ar_hs, r_last_hs;

  assign aw_s_data = {inport_awaddr_i, inport_awid_i,
                      inport_awlen_i, inport_awburst_i};
  assign ar_s_data = {inport_araddr_i, inport_arid_i,
                      inport_arlen_i, inport_arburst_i};
  assign w_s_data  = {inport_wdata_i, inport_wstrb_i, inport_wlast_i};
  assign b_s_data  = {outport_bresp_i, outport_bid_i};
  assign r_s_data  = {outport_rdata_i, outport_rresp_i,
                      outport_rid_i, outport_rlast_i};

  assign {outport_awaddr_o, outport_awid_o,
          outport_awlen_o, outport_awburst_o} = aw_m_data;
  assign {outport_araddr_o, outport_arid_o,
          outport_arlen_o, outport_arburst_o} = ar_m_data;
  assign {outport_wdata_o, outport_wstrb_o, outport_wlast_o} = w_m_data;
  assign {inport_bresp_o, inport_bid_o} = b_m_data;
  assign {inport_rdata_o, inport_rresp_o,
          inport_rid_o, inport_rlast_o} = r_m_data;

  // Address issue is held back, not the buffer contents.
  assign wr_full = (MAX_OUT != 0) && (wr_cnt == CMAX);
  assign rd_full = (MAX_OUT != 0) && (rd_cnt == CMAX);
  assign outport_awvalid_o = aw_m_valid & ~wr_full;
  assign aw_m_ready        = outport_awready_i & ~wr_full;
  assign outport_arvalid_o = ar_m_valid & ~rd_full;
  assign ar_m_ready        = outport_arready_i & ~rd_full;

  if (BYPASS[CH_AW]) begin : g_aw_byp
    assign aw_m_valid       = inport_awvalid_i;
    assign inport_awready_o = aw_m_ready;
    assign aw_m_data        = aw_s_data;
  end else begin : g_aw_buf
    ft60x_axi_fifo #(.WIDTH(AXW), .DEPTH(DEPTH)) u_fifo (
      .clk_i, .rst_ni,
      .valid_i(inport_awvalid_i), .data_i(aw_s_data),
      .accept_o(inport_awready_o), .valid_o(aw_m_valid),
      .data_o(aw_m_data), .ready_i(aw_m_ready));
  end

  if (BYPASS[CH_W]) begin : g_w_byp
    assign outport_wvalid_o = inport_wvalid_i;
    assign inport_wready_o  = outport_wready_i;
    assign w_m_data         = w_s_data;
  end else begin : g_w_buf
    ft60x_axi_fifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_fifo (
      .clk_i, .rst_ni,
      .valid_i(inport_wvalid_i), .data_i(w_s_data),
      .accept_o(inport_wready_o), .valid_o(outport_wvalid_o),
      .data_o(w_m_data), .ready_i(outport_wready_i));
  end

  if (BYPASS[CH_B]) begin : g_b_byp
    assign inport_bvalid_o  = outport_bvalid_i;
    assign outport_bready_o = inport_bready_i;
    assign b_m_data         = b_s_data;
  end else begin : g_b_buf
    ft60x_axi_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
      .clk_i, .rst_ni,
      .valid_i(outport_bvalid_i), .data_i(b_s_data),
      .accept_o(outport_bready_o), .valid_o(inport_bvalid_o),
      .data_o(b_m_data), .ready_i(inport_bready_i));
  end

  if (BYPASS[CH_AR]) begin : g_ar_byp
    assign ar_m_valid       = inport_arvalid_i;
    assign inport_arready_o = ar_m_ready;
    assign ar_m_data        = ar_s_data;
  end else begin : g_ar_buf
    ft60x_axi_fifo #(.WIDTH(AXW), .DEPTH(DEPTH)) u_fifo (
      .clk_i, .rst_ni,
      .valid_i(inport_arvalid_i), .data_i(ar_s_data),
      .accept_o(inport_arready_o), .valid_o(ar_m_valid),
      .data_o(ar_m_data), .ready_i(ar_m_ready));
  end

  if (BYPASS[CH_R]) begin : g_r_byp
    assign inport_rvalid_o  = outport_rvalid_i;
    assign outport_rready_o = inport_rready_i;
    assign r_m_data         = r_s_data;
  end else begin : g_r_buf
    ft60x_axi_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
      .clk_i, .rst_ni,
      .valid_i(outport_rvalid_i), .data_i(r_s_data),
      .accept_o(outport_rready_o), .valid_o(inport_rvalid_o),
      .data_o(r_m_data), .ready_i(inport_rready_i));
  end

  assign aw_hs     = outport_awvalid_o & outport_awready_i;
  assign b_hs      = inport_bvalid_o & inport_bready_i;
  assign ar_hs     = outport_arvalid_o & outport_arready_i;
  assign r_last_hs = inport_rvalid_o & inport_rready_i & inport_rlast_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (aw_hs && !b_hs && wr_cnt != CMAX)
        wr_cnt <= wr_cnt + 1'b1;
      else if (b_hs && !aw_hs && wr_cnt != '0)
        wr_cnt <= wr_cnt - 1'b1;
      if (ar_hs && !r_last_hs && rd_cnt != CMAX)
        rd_cnt <= rd_cnt + 1'b1;
      else if (r_last_hs && !ar_hs && rd_cnt != '0)
        rd_cnt <= rd_cnt - 1'b1;
    end
  end

  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;

endmodule

// File: tb/tb_ft60x_axi_buffer.sv
// Bench for ft60x_axi_buffer: a buffered, burst-capped instance
// and a fully bypassed instance driven from the same inputs.
module tb_ft60x_axi_buffer;

  localparam int D  = 4;
  localparam int MO = 2;

  typedef struct packed {
    logic [31:0] a; logic [3:0] id; logic [7:0] len; logic [1:0] bu;
  } ax_t;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} w_t;
  typedef struct packed {logic [1:0] rs; logic [3:0] id;} b_t;
  typedef struct packed {
    logic [31:0] d; logic [1:0] rs; logic [3:0] id; logic l;
  } r_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        inport_awvalid_i, inport_wvalid_i, inport_arvalid_i;
  logic [31:0] inport_awaddr_i, inport_araddr_i, inport_wdata_i;
  logic [3:0]  inport_awid_i, inport_arid_i, inport_wstrb_i;
  logic [7:0]  inport_awlen_i, inport_arlen_i;
  logic [1:0]  inport_awburst_i, inport_arburst_i;
  logic        inport_wlast_i, inport_bready_i, inport_rready_i;
  logic        outport_awready_i, outport_wready_i, outport_arready_i;
  logic        outport_bvalid_i, outport_rvalid_i, outport_rlast_i;
  logic [1:0]  outport_bresp_i, outport_rresp_i;
  logic [3:0]  outport_bid_i, outport_rid_i;
  logic [31:0] outport_rdata_i;

  logic        d_awready, d_wready, d_arready, d_bvalid, d_rvalid;
  logic [1:0]  d_bresp, d_rresp;
  logic [3:0]  d_bid, d_rid;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_o_awvalid, d_o_wvalid, d_o_arvalid;
  logic [31:0] d_o_awaddr, d_o_araddr, d_o_wdata;
  logic [3:0]  d_o_awid, d_o_arid, d_o_wstrb;
  logic [7:0]  d_o_awlen, d_o_arlen;
  logic [1:0]  d_o_awburst, d_o_arburst;
  logic        d_o_wlast, d_o_bready, d_o_rready;
  logic [1:0]  d_wr_out, d_rd_out;

  logic        y_awready, y_wready, y_arready, y_bvalid, y_rvalid;
  logic [1:0]  y_bresp, y_rresp;
  logic [3:0]  y_bid, y_rid;
  logic [31:0] y_rdata;
  logic        y_rlast;
  logic        y_o_awvalid, y_o_wvalid, y_o_arvalid;
  logic [31:0] y_o_awaddr, y_o_araddr, y_o_wdata;
  logic [3:0]  y_o_awid, y_o_arid, y_o_wstrb;
  logic [7:0]  y_o_awlen, y_o_arlen;
  logic [1:0]  y_o_awburst, y_o_arburst;
  logic        y_o_wlast, y_o_bready, y_o_rready;
  logic        y_wr_out, y_rd_out;

  ft60x_axi_buffer #(
    .DEPTH(D), .BYPASS(5'b00000), .MAX_OUT(MO)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inport_awvalid_i(inport_awvalid_i), .inport_awaddr_i(inport_awaddr_i),
    .inport_awid_i(inport_awid_i), .inport_awlen_i(inport_awlen_i),
    .inport_awburst_i(inport_awburst_i), .inport_awready_o(d_awready),
    .inport_wvalid_i(inport_wvalid_i), .inport_wdata_i(inport_wdata_i),
    .inport_wstrb_i(inport_wstrb_i), .inport_wlast_i(inport_wlast_i),
    .inport_wready_o(d_wready),
    .inport_bvalid_o(d_bvalid), .inport_bresp_o(d_bresp),
    .inport_bid_o(d_bid), .inport_bready_i(inport_bready_i),
    .inport_arvalid_i(inport_arvalid_i), .inport_araddr_i(inport_araddr_i),
    .inport_arid_i(inport_arid_i), .inport_arlen_i(inport_arlen_i),
    .inport_arburst_i(inport_arburst_i), .inport_arready_o(d_arready),
    .inport_rvalid_o(d_rvalid), .inport_rdata_o(d_rdata),
    .inport_rresp_o(d_rresp), .inport_rid_o(d_rid),
    .inport_rlast_o(d_rlast), .inport_rready_i(inport_rready_i),
    .outport_awvalid_o(d_o_awvalid), .outport_awaddr_o(d_o_awaddr),
    .outport_awid_o(d_o_awid), .outport_awlen_o(d_o_awlen),
    .outport_awburst_o(d_o_awburst), .outport_awready_i(outport_awready_i),
    .outport_wvalid_o(d_o_wvalid), .outport_wdata_o(d_o_wdata),
    .outport_wstrb_o(d_o_wstrb), .outport_wlast_o(d_o_wlast),
    .outport_wready_i(outport_wready_i),
    .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
    .outport_bid_i(outport_bid_i), .outport_bready_o(d_o_bready),
    .outport_arvalid_o(d_o_arvalid), .outport_araddr_o(d_o_araddr),
    .outport_arid_o(d_o_arid), .outport_arlen_o(d_o_arlen),
    .outport_arburst_o(d_o_arburst), .outport_arready_i(outport_arready_i),
    .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
    .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
    .outport_rlast_i(outport_rlast_i), .outport_rready_o(d_o_rready),
    .wr_outstanding_o(d_wr_out), .rd_outstanding_o(d_rd_out)
  );

  ft60x_axi_buffer #(
    .DEPTH(2), .BYPASS(5'b11111), .MAX_OUT(0)
  ) u_byp (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inport_awvalid_i(inport_awvalid_i), .inport_awaddr_i(inport_awaddr_i),
    .inport_awid_i(inport_awid_i), .inport_awlen_i(inport_awlen_i),
    .inport_awburst_i(inport_awburst_i), .inport_awready_o(y_awready),
    .inport_wvalid_i(inport_wvalid_i), .inport_wdata_i(inport_wdata_i),
    .inport_wstrb_i(inport_wstrb_i), .inport_wlast_i(inport_wlast_i),
    .inport_wready_o(y_wready),
    .inport_bvalid_o(y_bvalid), .inport_bresp_o(y_bresp),
    .inport_bid_o(y_bid), .inport_bready_i(inport_bready_i),
    .inport_arvalid_i(inport_arvalid_i), .inport_araddr_i(inport_araddr_i),
    .inport_arid_i(inport_arid_i), .inport_arlen_i(inport_arlen_i),
    .inport_arburst_i(inport_arburst_i), .inport_arready_o(y_arready),
    .inport_rvalid_o(y_rvalid), .inport_rdata_o(y_rdata),
    .inport_rresp_o(y_rresp), .inport_rid_o(y_rid),
    .inport_rlast_o(y_rlast), .inport_rready_i(inport_rready_i),
    .outport_awvalid_o(y_o_awvalid), .outport_awaddr_o(y_o_awaddr),
    .outport_awid_o(y_o_awid), .outport_awlen_o(y_o_awlen),
    .outport_awburst_o(y_o_awburst), .outport_awready_i(outport_awready_i),
    .outport_wvalid_o(y_o_wvalid), .outport_wdata_o(y_o_wdata),
    .outport_wstrb_o(y_o_wstrb), .outport_wlast_o(y_o_wlast),
    .outport_wready_i(outport_wready_i),
    .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
    .outport_bid_i(outport_bid_i), .outport_bready_o(y_o_bready),
    .outport_arvalid_o(y_o_arvalid), .outport_araddr_o(y_o_araddr),
    .outport_arid_o(y_o_arid), .outport_arlen_o(y_o_arlen),
    .outport_arburst_o(y_o_arburst), .outport_arready_i(outport_arready_i),
    .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
    .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
    .outport_rlast_i(outport_rlast_i), .outport_rready_o(y_o_rready),
    .wr_outstanding_o(y_wr_out), .rd_outstanding_o(y_rd_out)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  bit cap_en = 0;
  logic [31:0] cap[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per buffered channel, plain counters.
  ax_t awq[$], arq[$];
  w_t  wq[$];
  b_t  bq[$];
  r_t  rq[$];
  int  wr_m, rd_m, wr_b, rd_b;
  bit  aw_pop, ar_pop, w_pop, b_pop, r_pop, r_lst;
  bit  aw_push, ar_push, w_push, b_push, r_push;
  bit  y_aw, y_b, y_ar, y_r;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awq.delete(); arq.delete(); wq.delete(); bq.delete(); rq.delete();
      wr_m = 0; rd_m = 0; wr_b = 0; rd_b = 0;
    end else begin
      aw_pop  = awq.size() != 0 && wr_m < MO && outport_awready_i;
      ar_pop  = arq.size() != 0 && rd_m < MO && outport_arready_i;
      w_pop   = wq.size() != 0 && outport_wready_i;
      b_pop   = bq.size() != 0 && inport_bready_i;
      r_pop   = rq.size() != 0 && inport_rready_i;
      r_lst   = r_pop && rq[0].l;
      aw_push = inport_awvalid_i && awq.size() < D;
      ar_push = inport_arvalid_i && arq.size() < D;
      w_push  = inport_wvalid_i && wq.size() < D;
      b_push  = outport_bvalid_i && bq.size() < D;
      r_push  = outport_rvalid_i && rq.size() < D;
      if (aw_pop) void'(awq.pop_front());
      if (ar_pop) void'(arq.pop_front());
      if (w_pop)  void'(wq.pop_front());
      if (b_pop)  void'(bq.pop_front());
      if (r_pop)  void'(rq.pop_front());
      if (aw_push) awq.push_back({inport_awaddr_i, inport_awid_i,
                                  inport_awlen_i, inport_awburst_i});
      if (ar_push) arq.push_back({inport_araddr_i, inport_arid_i,
                                  inport_arlen_i, inport_arburst_i});
      if (w_push) wq.push_back({inport_wdata_i, inport_wstrb_i,
                                inport_wlast_i});
      if (b_push) bq.push_back({outport_bresp_i, outport_bid_i});
      if (r_push) rq.push_back({outport_rdata_i, outport_rresp_i,
                                outport_rid_i, outport_rlast_i});
      if (aw_pop && !b_pop && wr_m < MO) wr_m++;
      else if (b_pop && !aw_pop && wr_m > 0) wr_m--;
      if (ar_pop && !r_lst && rd_m < MO) rd_m++;
      else if (r_lst && !ar_pop && rd_m > 0) rd_m--;
      y_aw = inport_awvalid_i && outport_awready_i;
      y_b  = outport_bvalid_i && inport_bready_i;
      y_ar = inport_arvalid_i && outport_arready_i;
      y_r  = outport_rvalid_i && inport_rready_i && outport_rlast_i;
      if (y_aw && !y_b && wr_b < 1) wr_b++;
      else if (y_b && !y_aw && wr_b > 0) wr_b--;
      if (y_ar && !y_r && rd_b < 1) rd_b++;
      else if (y_r && !y_ar && rd_b > 0) rd_b--;
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("aw_valid", d_o_awvalid, awq.size() != 0 && wr_m < MO);
      if (awq.size() != 0 && wr_m < MO)
        chk("aw_data", {d_o_awaddr, d_o_awid, d_o_awlen, d_o_awburst},
            awq[0]);
      chk("aw_ready", d_awready, awq.size() < D);
      chk("ar_valid", d_o_arvalid, arq.size() != 0 && rd_m < MO);
      if (arq.size() != 0 && rd_m < MO)
        chk("ar_data", {d_o_araddr, d_o_arid, d_o_arlen, d_o_arburst},
            arq[0]);
      chk("ar_ready", d_arready, arq.size() < D);
      chk("w_valid", d_o_wvalid, wq.size() != 0);
      if (wq.size() != 0)
        chk("w_data", {d_o_wdata, d_o_wstrb, d_o_wlast}, wq[0]);
      chk("w_ready", d_wready, wq.size() < D);
      chk("b_valid", d_bvalid, bq.size() != 0);
      if (bq.size() != 0) chk("b_data", {d_bresp, d_bid}, bq[0]);
      chk("b_ready", d_o_bready, bq.size() < D);
      chk("r_valid", d_rvalid, rq.size() != 0);
      if (rq.size() != 0)
        chk("r_data", {d_rdata, d_rresp, d_rid, d_rlast}, rq[0]);
      chk("r_ready", d_o_rready, rq.size() < D);
      chk("wr_cnt", d_wr_out, wr_m);
      chk("rd_cnt", d_rd_out, rd_m);
      chk("byp_aw", {y_o_awvalid, y_o_awaddr, y_o_awid, y_o_awlen,
                     y_o_awburst, y_awready},
          {inport_awvalid_i, inport_awaddr_i, inport_awid_i,
           inport_awlen_i, inport_awburst_i, outport_awready_i});
      chk("byp_ar", {y_o_arvalid, y_o_araddr, y_o_arid, y_o_arlen,
                     y_o_arburst, y_arready},
          {inport_arvalid_i, inport_araddr_i, inport_arid_i,
           inport_arlen_i, inport_arburst_i, outport_arready_i});
      chk("byp_w", {y_o_wvalid, y_o_wdata, y_o_wstrb, y_o_wlast, y_wready},
          {inport_wvalid_i, inport_wdata_i, inport_wstrb_i,
           inport_wlast_i, outport_wready_i});
      chk("byp_b", {y_bvalid, y_bresp, y_bid, y_o_bready},
          {outport_bvalid_i, outport_bresp_i, outport_bid_i,
           inport_bready_i});
      chk("byp_r", {y_rvalid, y_rdata, y_rresp, y_rid, y_rlast, y_o_rready},
          {outport_rvalid_i, outport_rdata_i, outport_rresp_i,
           outport_rid_i, outport_rlast_i, inport_rready_i});
      chk("byp_wr_cnt", y_wr_out, wr_b);
      chk("byp_rd_cnt", y_rd_out, rd_b);
    end
  end

  always @(negedge clk_i) begin
    if (cap_en && d_o_awvalid && outport_awready_i)
      cap.push_back(d_o_awaddr);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    inport_awvalid_i = 0; inport_awaddr_i = '0; inport_awid_i = '0;
    inport_awlen_i = '0; inport_awburst_i = '0;
    inport_arvalid_i = 0; inport_araddr_i = '0; inport_arid_i = '0;
    inport_arlen_i = '0; inport_arburst_i = '0;
    inport_wvalid_i = 0; inport_wdata_i = '0; inport_wstrb_i = '0;
    inport_wlast_i = 0; inport_bready_i = 0; inport_rready_i = 0;
    outport_awready_i = 0; outport_wready_i = 0; outport_arready_i = 0;
    outport_bvalid_i = 0; outport_bresp_i = '0; outport_bid_i = '0;
    outport_rvalid_i = 0; outport_rdata_i = '0; outport_rresp_i = '0;
    outport_rid_i = '0; outport_rlast_i = 0;
  endtask

  task automatic randomize_inputs();
    inport_awvalid_i  = $urandom_range(0, 99) < 50;
    inport_awaddr_i   = $urandom;
    inport_awid_i     = 4'($urandom);
    inport_awlen_i    = 8'($urandom);
    inport_awburst_i  = 2'($urandom);
    inport_arvalid_i  = $urandom_range(0, 99) < 50;
    inport_araddr_i   = $urandom;
    inport_arid_i     = 4'($urandom);
    inport_arlen_i    = 8'($urandom);
    inport_arburst_i  = 2'($urandom);
    inport_wvalid_i   = $urandom_range(0, 99) < 60;
    inport_wdata_i    = $urandom;
    inport_wstrb_i    = 4'($urandom);
    inport_wlast_i    = 1'($urandom);
    inport_bready_i   = $urandom_range(0, 99) < 70;
    inport_rready_i   = $urandom_range(0, 99) < 70;
    outport_awready_i = $urandom_range(0, 99) < 70;
    outport_wready_i  = $urandom_range(0, 99) < 70;
    outport_arready_i = $urandom_range(0, 99) < 70;
    outport_bvalid_i  = $urandom_range(0, 99) < 40;
    outport_bresp_i   = 2'($urandom);
    outport_bid_i     = 4'($urandom);
    outport_rvalid_i  = $urandom_range(0, 99) < 60;
    outport_rdata_i   = $urandom;
    outport_rresp_i   = 2'($urandom);
    outport_rid_i     = 4'($urandom);
    outport_rlast_i   = $urandom_range(0, 99) < 40;
  endtask

  initial begin
    idle();
    rst_ni = 0;
    repeat (3) step();
    rst_ni = 1;
    cmp_en = 1;
    @(negedge clk_i);
    chk("rst_awready", d_awready, 1);
    chk("rst_awvalid", d_o_awvalid, 0);
    chk("rst_bvalid", d_bvalid, 0);
    chk("rst_wr_cnt", d_wr_out, 0);
    step();

    // Write path: fill the 4-deep AW buffer, then cap at 2 outstanding.
    cap_en = 1;
    for (int i = 0; i < 5; i++) begin
      inport_awvalid_i = 1;
      inport_awaddr_i = 32'h100 + 32'(i);
      step();
    end
    @(negedge clk_i);
    chk("aw_full_ready", d_awready, 0);
    step();
    outport_awready_i = 1;
    repeat (2) step();
    inport_awvalid_i = 0;
    step();
    @(negedge clk_i);
    chk("aw_capped_valid", d_o_awvalid, 0);
    chk("aw_capped_cnt", d_wr_out, 2);
    chk("aw_cap_n2", cap.size(), 2);
    step();
    inport_bready_i = 1;
    outport_bvalid_i = 1;
    outport_bid_i = 4'h1;
    repeat (2) step();
    outport_bvalid_i = 0;
    step();
    @(negedge clk_i);
    chk("wr_same_cycle_hold", d_wr_out, 1);
    step();
    outport_bvalid_i = 1;
    repeat (4) step();
    outport_bvalid_i = 0;
    repeat (8) step();
    cap_en = 0;
    chk("aw_cap_n5", cap.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < cap.size()) chk("aw_order", cap[i], 32'h100 + 32'(i));
    chk("wr_drained", d_wr_out, 0);

    // Read path: 3 ARs against a limit of 2, released by one last beat.
    idle();
    outport_arready_i = 1;
    for (int i = 0; i < 3; i++) begin
      inport_arvalid_i = 1;
      inport_araddr_i = 32'h200 + 32'(i);
      step();
    end
    inport_arvalid_i = 0;
    step();
    @(negedge clk_i);
    chk("ar_capped_valid", d_o_arvalid, 0);
    chk("ar_capped_cnt", d_rd_out, 2);
    step();
    outport_rvalid_i = 1;
    outport_rlast_i = 1;
    outport_rdata_i = 32'h55;
    inport_rready_i = 1;
    step();
    outport_rvalid_i = 0;
    step();
    @(negedge clk_i);
    chk("ar_release_valid", d_o_arvalid, 1);
    chk("ar_release_addr", d_o_araddr, 32'h202);
    chk("ar_release_cnt", d_rd_out, 1);
    step();
    @(negedge clk_i);
    chk("ar_reissue_cnt", d_rd_out, 2);
    step();

    // Fill every buffer, then reset with entries in flight.
    idle();
    inport_awvalid_i = 1; inport_arvalid_i = 1; inport_wvalid_i = 1;
    outport_bvalid_i = 1; outport_rvalid_i = 1;
    inport_wdata_i = 32'hDEADBEEF;
    #1;
    chk("byp_wdata", y_o_wdata, 32'hDEADBEEF);
    chk("byp_wvalid", y_o_wvalid, 1);
    repeat (2) step();
    idle();
    chk("pre_rst_wvalid", d_o_wvalid, 1);
    chk("pre_rst_bvalid", d_bvalid, 1);
    rst_ni = 0;
    #1;
    chk("rst_now_valids",
        {d_o_awvalid, d_o_wvalid, d_bvalid, d_o_arvalid, d_rvalid}, 0);
    chk("rst_now_readies",
        {d_awready, d_wready, d_o_bready, d_arready, d_o_rready}, 5'h1f);
    chk("rst_now_cnts", {d_wr_out, d_rd_out}, 0);
    repeat (2) step();
    rst_ni = 1;
    @(negedge clk_i);
    chk("post_rst_readies",
        {d_awready, d_wready, d_o_bready, d_arready, d_o_rready}, 5'h1f);
    chk("post_rst_valids",
        {d_o_awvalid, d_o_wvalid, d_bvalid, d_o_arvalid, d_rvalid}, 0);
    chk("post_rst_cnts", {d_wr_out, d_rd_out}, 0);
    step();

    // Random traffic with one reset pulse in the middle.
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      if (c == 1500) rst_ni = 0;
      if (c == 1503) rst_ni = 1;
      step();
    end
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
